// File: rtl/control_riesgos_pkg.sv
// Shared constants for the hazard/pipeline-control unit and the pipeline buffers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package control_riesgos_pkg;

    // Control FSM encoding
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_ESPERA = 1'b1;

    // Bit positions inside the M control field of the pipeline buffers
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // Control field widths carried by ID/EX and later buffers
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // Load-use hazard: the load in ID/EX writes a register the instruction in ID reads.
    // Register 0 is hard-wired to zero, so a load "into" r0 never creates a dependency.
    function automatic logic riesgo_carga(
        input logic       memread,
        input logic [4:0] rt_carga,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id,
        input logic       usa_rt
    );
        return memread && (rt_carga != 5'd0) &&
               ((rt_carga == rs_id) || (usa_rt && (rt_carga == rt_id)));
    endfunction

endpackage

// File: rtl/control_riesgos_contador.sv
// Saturating event counter: clr by async reset, +1 per enabled edge, sticks at all-ones.
// Latency: count visible one edge after inc_i.
// Backpressure: none; increment requests at saturation are dropped.
// Ports: clk, rst (async active-high), inc_i (increment enable), cnt_o (count).
module contador_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/control_riesgos.sv
// Hazard/pipeline-control unit: load-use bubbles, branch flushes, memory-wait freezes.
// Latency: control outputs are combinational; counters/err_timeout update on the next edge.
// Backpressure: mem_wait freezes every pipeline register; a taken branch waits until it drops.
// Ports: IF/ID fields (id_rs, id_rt, id_usa_rt), ID/EX load info (idex_memread, idex_rt),
//        br_tomado, mem_wait in; stage enables/flushes, pc_src, event counters, err_timeout out.
module control_riesgos
    import control_riesgos_pkg::*;
#(
    parameter int CW         = 16,
    parameter int MAX_ESPERA = 64,
    parameter int WW         = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_usa_rt,
    input  logic          idex_memread,
    input  logic [4:0]    idex_rt,
    input  logic          br_tomado,
    input  logic          mem_wait,
    output logic          pc_write,
    output logic          pc_src,
    output logic          ifid_write,
    output logic          idex_write,
    output logic          exmem_write,
    output logic          idex_burbuja,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          exmem_flush,
    output logic [CW-1:0] cnt_burbujas,
    output logic [CW-1:0] cnt_vaciados,
    output logic [CW-1:0] cnt_congelado,
    output logic          err_timeout
);

    localparam logic [WW-1:0] ESPERA_MAX = WW'(MAX_ESPERA);

    logic          hz;
    logic          ev_congelo;
    logic          ev_vaciado;
    logic          ev_burbuja;
    logic [0:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    assign hz = riesgo_carga(idex_memread, idex_rt, id_rs, id_rt, id_usa_rt);

    // Priority: reset > freeze > taken branch > load-use > normal.
    // A taken branch beats a hazard because the dependent instruction is on the wrong path.
    assign ev_congelo = !rst && mem_wait;
    assign ev_vaciado = !rst && !mem_wait && br_tomado;
    assign ev_burbuja = !rst && !mem_wait && !br_tomado && hz;

    always_comb begin
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        idex_burbuja = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_wait) begin
            // Everything holds, including EX/MEM, so br_tomado persists and is
            // serviced on the first cycle the memory is ready.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (br_tomado) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hz) begin
            // Hold PC and IF/ID, let a bubble into ID/EX; next cycle the load sits
            // in EX/MEM so the hazard clears without extra state.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_burbuja = 1'b1;
        end
    end

    // Freeze tracking: the wait counter restarts on entry to ESPERA and saturates.
    always_comb begin
        state_d = mem_wait ? ST_ESPERA : ST_RUN;
        wait_d  = '0;
        if (mem_wait) begin
            if (state_q == ST_RUN) begin
                wait_d = WW'(1);
            end else if (wait_q != ESPERA_MAX) begin
                wait_d = wait_q + 1'b1;
            end else begin
                wait_d = wait_q;
            end
        end
        // Sticky; it only reports, the freeze continues while mem_wait holds.
        err_d = err_q || (mem_wait && (wait_q == ESPERA_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign err_timeout = err_q;

    contador_sat #(.W(CW)) u_cnt_burbujas (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ev_burbuja),
        .cnt_o (cnt_burbujas)
    );

    contador_sat #(.W(CW)) u_cnt_vaciados (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ev_vaciado),
        .cnt_o (cnt_vaciados)
    );

    contador_sat #(.W(CW)) u_cnt_congelado (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ev_congelo),
        .cnt_o (cnt_congelado)
    );

endmodule

// File: doc/control_riesgos.md
Name: control_riesgos

Overview:
- Hazard and pipeline-control unit for the 5-stage MIPS pipeline; consumer end of the ID/EX buffer.
- Reads the ID/EX buffer outputs (load flag, destination rt) and the IF/ID register fields, and drives the write-enables and flushes of PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use bubbles, taken-branch flushes (branch resolved in MEM) and data-memory wait freezes.
- Keeps saturating event counters and a sticky memory-timeout error.

Parameters:
- CW, 16, width of each event counter.
- MAX_ESPERA, 64, maximum consecutive freeze cycles before err_timeout sets.
- WW, 7, width of the wait counter; must satisfy 2^WW > MAX_ESPERA.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in IF/ID.
- id_rt  in  5  rt field of the instruction in IF/ID.
- id_usa_rt  in  1  instruction in ID reads rt as a source.
- idex_memread  in  1  MemRead bit, M[1], of the ID/EX buffer output.
- idex_rt  in  5  rt field held in ID/EX, the load destination.
- br_tomado  in  1  branch in EX/MEM is taken (Branch & Zero).
- mem_wait  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  1  1 selects the branch target.
- ifid_write  out  1  IF/ID enable.
- idex_write  out  1  ID/EX enable.
- exmem_write  out  1  EX/MEM and MEM/WB enable.
- idex_burbuja  out  1  zero WB/M/EX control bits entering ID/EX.
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX.
- exmem_flush  out  1  clear EX/MEM control bits.
- cnt_burbujas  out  CW  load-use bubbles inserted.
- cnt_vaciados  out  CW  branch flushes performed.
- cnt_congelado  out  CW  freeze cycles.
- err_timeout  out  1  sticky memory-timeout error.

Behaviour:
- Load-use hazard: hz = idex_memread & (idex_rt != 0) & ((idex_rt == id_rs) | (id_usa_rt & idex_rt == id_rt)).
- FSM, registered state:
  - RUN: normal operation.
  - ESPERA: a freeze is in progress.
  - RUN -> ESPERA when mem_wait = 1; ESPERA -> RUN when mem_wait = 0; ESPERA stays in ESPERA while mem_wait = 1.
- Control outputs are combinational from the current inputs. Evaluate in priority order:
  1. rst = 1: all enables 0, all flushes 1, pc_src = 0.
  2. mem_wait = 1 (freeze): pc_write, ifid_write, idex_write and exmem_write are 0; all flushes and burbuja are 0.
     - br_tomado is ignored while frozen. It stays asserted because EX/MEM holds, and is serviced on the first non-wait cycle.
  3. br_tomado = 1: pc_src = 1, pc_write = 1, and ifid_flush, idex_flush and exmem_flush are 1.
     - Any simultaneous hz is ignored because that instruction is on the wrong path.
  4. hz = 1: pc_write = 0, ifid_write = 0, idex_burbuja = 1, idex_write = 1, exmem_write = 1.
  5. Otherwise: all enables 1; pc_src, flushes and burbuja are 0.
- Default enables: any output not named in a case above takes its case-5 value.
- One bubble per load-use: the following cycle the load is in EX/MEM, so hz clears naturally. No extra state is needed.
- Wait counter:
  - Counts cycles in which mem_wait = 1; cleared on any cycle with mem_wait = 0.
  - When it reaches MAX_ESPERA with mem_wait still 1, err_timeout sets at the next edge.
  - err_timeout stays set until rst. It does not release the freeze.
  - The wait counter saturates at MAX_ESPERA.
- Event counters increment at the clock edge when the corresponding case (2, 3 or 4) is active. They saturate at all-ones and never wrap.
- Reset values: state RUN; wait counter, all event counters and err_timeout are 0.
  - Reset is asynchronous and may arrive mid-freeze; the unit returns to RUN with all counters cleared.
  - Outputs are meaningful from the first edge after rst deasserts.

Decomposition:
- Shared package: state encoding (RUN = 0, ESPERA = 1), the M-field bit index constants (M_BRANCH = 2, M_MEMREAD = 1, M_MEMWRITE = 0) and the WB/EX field widths shared with the pipeline buffers.
- One sub-module: contador_sat, a parameterised-width saturating counter with increment enable and async reset, instanced three times.

Test Plan:
- Load-use: idex_memread = 1, idex_rt = 5, id_rs = 5 -> pc_write = 0, ifid_write = 0, idex_burbuja = 1 for exactly one cycle; cnt_burbujas = 1. Repeat with idex_rt = 0 -> no stall.
- rt-only hazard: id_rt = 7, id_usa_rt = 0, idex_rt = 7, idex_memread = 1 -> no stall. Same with id_usa_rt = 1 -> stall.
- Branch over hazard: br_tomado = 1 together with hz = 1 -> three flushes = 1, pc_src = 1, idex_burbuja = 0; cnt_vaciados = 1, cnt_burbujas unchanged.
- Freeze with pending branch: mem_wait = 1 for 3 cycles with br_tomado = 1 -> all enables 0 and no flush for those 3 cycles; the flush occurs on the 4th cycle; cnt_congelado = 3.
- Timeout: mem_wait held for 70 cycles with MAX_ESPERA = 64 -> err_timeout rises after cycle 64 and stays 1 after mem_wait drops; cleared only by rst.
- Reset mid-freeze: rst pulse at cycle 2 of a wait -> state RUN and counters 0 immediately, without waiting for a clock edge; with CW = 4, 20 bubbles -> cnt_burbujas = 15.
